// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//
// Contents:
//   tx_state_e  - frame sequencer states
//   divisor()   - clocks per bit, rounded to nearest
//   DATA_BITS   - payload bits per frame
//   FRAME_BITS  - line bits per frame (start + data [+ parity] + stop)
//
// Optional feature: define UART_TX_ARB_PARITY_EN to add an even-parity bit.

package uart_tx_arb_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_ARB_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;
`else
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;
`endif

  // Clock cycles per bit; the design relies on the result being at least 2.
  function automatic int unsigned divisor(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer for the UART transmitter.
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear; holds the count at zero while asserted
//   tick_o  - one-cycle pulse on the last cycle of each bit period
//
// The count restarts from zero whenever clr_i is released, so every bit
// boundary lines up with the start bit of the current frame.

module baud_tick #(
  parameter int unsigned DIVISOR = 313
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(DIVISOR);
  localparam logic [CntW-1:0] CntMax = CntW'(DIVISOR - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = ~clr_i & (cnt_q == CntMax);
    cnt_d  = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX line among N_REQ byte sources.
//
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset; abandons any frame in flight
//   req_i    - per-requester level request
//   data_i   - byte for requester k at bits [8k+7:8k], captured on the grant edge
//   gnt_o    - one-hot, one-cycle grant pulse
//   owner_o  - index of the requester owning the current/last frame
//   busy_o   - high for every cycle of a frame
//   tx_o     - serial line, idles high
//
// Frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional feature: define UART_TX_ARB_PARITY_EN to insert the parity bit.
// Every output is registered; a frame starts on the cycle after the grant edge.

module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned CLK_HZ = 3_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DATA_BITS-1:0] data_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [$clog2(N_REQ)-1:0]   owner_o,
  output logic                       busy_o,
  output logic                       tx_o
);

  localparam int unsigned IdxW    = $clog2(N_REQ);
  localparam int unsigned Divisor = divisor(CLK_HZ, BAUD);
  localparam logic [IdxW-1:0] LastRst = IdxW'(N_REQ - 1);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [IdxW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_ARB_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic            tick;
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;

  // Timer is held cleared in idle so the first tick lands DIVISOR cycles after the grant.
  baud_tick #(
    .DIVISOR (Divisor)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q == StIdle),
    .tick_o (tick)
  );

  // Round-robin search starting just after the previous winner, wrapping at N_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = IdxW'((int'(last_q) + i) % int'(N_REQ));
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    last_d    = last_q;
    owner_d   = owner_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    tx_d      = tx_q;
`ifdef UART_TX_ARB_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          shift_d   = data_i[{win_idx, 3'b000} +: DATA_BITS];
          bit_idx_d = '0;
          last_d    = win_idx;
          owner_d   = win_idx;
          gnt_d     = N_REQ'(1) << win_idx;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
          parity_d  = ^data_i[{win_idx, 3'b000} +: DATA_BITS];
`endif
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_idx_q == LastBit) begin
`ifdef UART_TX_ARB_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            // shift_q[0] is the bit on the line; the next one is shift_q[1].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      StParity: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      last_q    <= LastRst;
      owner_q   <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
`ifdef UART_TX_ARB_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;
  assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a default instance (N_REQ=2, DIVISOR=313)
// and a fast 4-requester instance (DIVISOR=4) for round-robin and randomized traffic.

module tb_uart_tx_arbiter;

  localparam int DIV_A = 313;
  localparam int DIV_B = 4;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  req_a;
  logic [15:0] data_a;
  logic [1:0]  gnt_a;
  logic        owner_a;
  logic        busy_a, tx_a;

  logic [3:0]  req_b;
  logic [31:0] data_b;
  logic [3:0]  gnt_b;
  logic [1:0]  owner_b;
  logic        busy_b, tx_b;

  uart_tx_arbiter #(
    .N_REQ  (2),
    .CLK_HZ (3_000_000),
    .BAUD   (9600)
  ) dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req_a),
    .data_i  (data_a),
    .gnt_o   (gnt_a),
    .owner_o (owner_a),
    .busy_o  (busy_a),
    .tx_o    (tx_a)
  );

  uart_tx_arbiter #(
    .N_REQ  (4),
    .CLK_HZ (40),
    .BAUD   (10)
  ) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req_b),
    .data_i  (data_b),
    .gnt_o   (gnt_b),
    .owner_o (owner_b),
    .busy_o  (busy_b),
    .tx_o    (tx_b)
  );

  // Monitor view of whichever instance is under test.
  logic       sel;
  logic [3:0] m_gnt;
  logic [1:0] m_owner;
  logic       m_busy, m_tx;
  assign m_gnt   = sel ? gnt_b : {2'b00, gnt_a};
  assign m_owner = sel ? owner_b : {1'b0, owner_a};
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_tx    = sel ? tx_b : tx_a;

  int checks = 0;
  int errors = 0;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a grant; it must appear exactly lat negedges after the call.
  task automatic wait_gnt(input int lat, input string name);
    int n;
    n = 0;
    while (n < 20 * DIV_A) begin
      @(negedge clk);
      n++;
      if (m_gnt !== '0) break;
    end
    checks++;
    if (m_gnt === '0 || n != lat) begin
      errors++;
      $display("FAIL %s grant latency: got %0d cycles (gnt=%b), required %0d", name, n, m_gnt, lat);
    end
  endtask

  // Called on the first frame cycle; returns on the idle cycle that follows the frame.
  task automatic check_frame(input logic [7:0] b, input int own, input string name);
    logic [NBITS-1:0] exp;
    logic [3:0] eg;
    int d;
    d = sel ? DIV_B : DIV_A;
    exp = '1;
    exp[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp[i+1] = b[i];
`ifdef UART_TX_ARB_PARITY_EN
    exp[9] = ^b;
`endif
    eg = 4'(1) << own;
    checks++;
    if (m_gnt !== eg || m_owner !== own[1:0]) begin
      errors++;
      $display("FAIL %s grant: gnt=%b owner=%0d, required gnt=%b owner=%0d",
               name, m_gnt, m_owner, eg, own);
    end
    for (int k = 0; k < NBITS; k++) begin
      bit ok;
      logic bt, bb;
      logic [3:0] bg;
      ok = 1'b1;
      bt = 1'b0; bb = 1'b0; bg = '0;
      for (int c = 0; c < d; c++) begin
        if (ok && (m_tx !== exp[k] || m_busy !== 1'b1 || m_owner !== own[1:0] ||
                   ((k != 0 || c != 0) && m_gnt !== '0))) begin
          ok = 1'b0;
          bt = m_tx; bb = m_busy; bg = m_gnt;
        end
        @(negedge clk);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s bit %0d: tx=%b busy=%b gnt=%b, required tx=%b busy=1 gnt=0",
                 name, k, bt, bb, bg, exp[k]);
      end
    end
    checks++;
    if (m_busy !== 1'b0 || m_tx !== 1'b1 || m_gnt !== '0 || m_owner !== own[1:0]) begin
      errors++;
      $display("FAIL %s idle after frame: busy=%b tx=%b gnt=%b owner=%0d, required 0/1/0/%0d",
               name, m_busy, m_tx, m_gnt, m_owner, own);
    end
  endtask

  task automatic test_reset();
    sel    = 1'b0;
    rst_n  = 1'b0;
    req_a  = '0;
    req_b  = '0;
    data_a = '0;
    data_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || gnt_a !== '0 || owner_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: tx=%b busy=%b gnt=%b owner=%0d, required 1/0/00/0",
               tx_a, busy_a, gnt_a, owner_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || gnt_b !== '0 || owner_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_b: tx=%b busy=%b gnt=%b owner=%0d, required 1/0/0000/0",
               tx_b, busy_b, gnt_b, owner_b);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || gnt_a !== '0) begin
      errors++;
      $display("FAIL idle_no_req: tx=%b busy=%b gnt=%b, required 1/0/00", tx_a, busy_a, gnt_a);
    end
  endtask

  task automatic test_single();
    sel = 1'b0;
    data_a[7:0] = 8'h55;
    req_a = 2'b01;
    wait_gnt(1, "single");
    req_a = 2'b00;
    check_frame(8'h55, 0, "single");
  endtask

  task automatic test_simultaneous();
    int t0;
    sel = 1'b0;
    do_reset();
    data_a = {8'h3C, 8'hA1};
    req_a = 2'b11;
    wait_gnt(1, "simul_first");
    t0 = cyc;
    req_a = 2'b10;
    check_frame(8'hA1, 0, "simul_first");
    wait_gnt(1, "simul_second");
    checks++;
    if (cyc - t0 != NBITS * DIV_A + 1) begin
      errors++;
      $display("FAIL simul_spacing: got %0d cycles, required %0d", cyc - t0, NBITS * DIV_A + 1);
    end
    req_a = 2'b00;
    check_frame(8'h3C, 1, "simul_second");
  endtask

  task automatic test_rotation();
    logic [7:0] b;
    int own;
    sel = 1'b0;
    do_reset();
    data_a = 16'($urandom);
    req_a = 2'b11;
    for (int f = 0; f < 4; f++) begin
      own = f % 2;
      b = data_a[own*8 +: 8];
      wait_gnt(1, "rotation");
      data_a[own*8 +: 8] = 8'($urandom);
      if (f == 3) req_a = 2'b00;
      check_frame(b, own, "rotation");
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    sel = 1'b0;
    do_reset();
    // Bit 2 cleared so the line is low at cycle 1000 (frame bit 3).
    b = 8'($urandom) & 8'hFB;
    data_a[7:0] = b;
    req_a = 2'b01;
    wait_gnt(1, "midreset");
    req_a = 2'b00;
    repeat (1000) @(negedge clk);
    checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: tx=%b busy=%b, required 0/1", tx_a, busy_a);
    end
    rst_n = 1'b0;
    req_a = 2'b10;
    data_a[15:8] = 8'($urandom);
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || gnt_a !== '0) begin
      errors++;
      $display("FAIL midreset_async: tx=%b busy=%b gnt=%b, required 1/0/00", tx_a, busy_a, gnt_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (gnt_a !== '0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold: gnt=%b busy=%b, required 00/0", gnt_a, busy_a);
    end
    rst_n = 1'b1;
    wait_gnt(1, "midreset_after");
    req_a = 2'b00;
    check_frame(data_a[15:8], 1, "midreset_after");
  endtask

  task automatic test_rr_n4();
    sel = 1'b1;
    do_reset();
    data_b = $urandom;
    req_b = 4'b0010;
    wait_gnt(1, "n4_prime");
    req_b = 4'b0000;
    check_frame(data_b[15:8], 1, "n4_prime");
    req_b = 4'b1001;
    wait_gnt(1, "n4_first");
    req_b = 4'b0001;
    check_frame(data_b[31:24], 3, "n4_first");
    wait_gnt(1, "n4_second");
    req_b = 4'b0000;
    check_frame(data_b[7:0], 0, "n4_second");
  endtask

  // Reference: pick the first requesting index after the previous winner, with wrap.
  task automatic test_random();
    int last_m;
    int w;
    int r;
    logic [7:0] b;
    sel = 1'b1;
    do_reset();
    last_m = 3;
    for (int it = 0; it < 40; it++) begin
      for (int q = 0; q < 4; q++) begin
        if (!req_b[q]) begin
          if ($urandom_range(1, 0) == 1) begin
            req_b[q] = 1'b1;
            data_b[q*8 +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(7, 0) == 0) begin
          req_b[q] = 1'b0;
        end
      end
      if (req_b == 4'b0000) begin
        r = $urandom_range(3, 0);
        req_b[r] = 1'b1;
        data_b[r*8 +: 8] = 8'($urandom);
      end
      w = 0;
      for (int i = 1; i <= 4; i++) begin
        if (req_b[(last_m + i) % 4]) begin
          w = (last_m + i) % 4;
          break;
        end
      end
      b = data_b[w*8 +: 8];
      wait_gnt(1, "random");
      last_m = w;
      if ($urandom_range(1, 0) == 1) req_b[w] = 1'b0;
      else data_b[w*8 +: 8] = 8'($urandom);
      check_frame(b, w, "random");
    end
    req_b = 4'b0000;
  endtask

`ifdef UART_TX_ARB_PARITY_EN
  task automatic test_parity();
    int t0;
    sel = 1'b0;
    do_reset();
    data_a[7:0] = 8'h07;
    req_a = 2'b01;
    wait_gnt(1, "parity");
    t0 = cyc;
    req_a = 2'b00;
    check_frame(8'h07, 0, "parity");
    checks++;
    if (cyc - t0 != 11 * DIV_A) begin
      errors++;
      $display("FAIL parity_frame_len: got %0d cycles, required %0d", cyc - t0, 11 * DIV_A);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_rotation();
    test_reset_mid();
    test_rr_n4();
    test_random();
`ifdef UART_TX_ARB_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmit line among `N_REQ` byte sources. It runs round-robin arbitration and sequences the 8N1 frame itself. Baud timing comes from an internal divider that restarts at each frame start, so every bit boundary is aligned to the start bit. It sits between on-chip message producers and the board's TX pin, clocked from the 3 MHz system clock.

## Interface
- `N_REQ`, 2: number of requesters, range 2–8.
- `CLK_HZ`, 3_000_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  `N_REQ`  per-requester request, level.
- `data_i`  in  `N_REQ*8`  byte for requester k, at bits [8k+7:8k].
- `gnt_o`  out  `N_REQ`  one-hot grant pulse, one cycle.
- `owner_o`  out  `$clog2(N_REQ)`  index of the requester currently transmitting.
- `busy_o`  out  1  a frame is in progress.
- `tx_o`  out  1  serial line, idles high.

## Operation
- `DIVISOR = (CLK_HZ + BAUD/2) / BAUD`, rounded to nearest. Requires `DIVISOR >= 2`. Baud counter width is `$clog2(DIVISOR)`.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
- **IDLE**
  - If any `req_i` bit is set, select the winner by round-robin: search from `(last_q+1) mod N_REQ` upward with wrap.
  - Latch the winner's byte into the shift register, set `last_q` and `owner_o` to the winner, clear the baud counter, go to START.
- **START**: `tx_o=0` for `DIVISOR` cycles, then go to DATA.
- **DATA**: 8 bits, LSB first, `DIVISOR` cycles each. A 3-bit bit index counts 0..7; after bit 7, go to STOP.
- **STOP**: `tx_o=1` for `DIVISOR` cycles, then go to IDLE.
- Handshake:
  - A requester holds `req_i` and its `data_i` stable until it sees its `gnt_o` bit.
  - Data is captured on the granting edge. `data_i` is don't-care afterwards.
  - A requester that keeps `req_i` high after its grant is treated as a new request.
- Requests that arrive while `busy_o=1` wait; nothing is dropped or queued beyond the level `req_i`.
- A requester that deasserts `req_i` before being granted is simply not considered.
- Reset values: `tx_o=1`, `busy_o=0`, `gnt_o=0`, `owner_o=0`, `last_q=N_REQ-1` (so requester 0 has priority first), state IDLE.
- Reset mid-frame: the frame is abandoned immediately (`tx_o=1` asynchronously) and no grant is issued. After release, arbitration restarts from `last_q=N_REQ-1`.

## Timing
- Grant edge E: from cycle E+1, `gnt_o` is high for exactly one cycle, `tx_o` falls, and `busy_o` rises. All outputs are registered.
- Frame length is `10*DIVISOR` cycles; `busy_o` is high for all of them.
- STOP ends with one IDLE cycle, so the back-to-back grant spacing is `10*DIVISOR+1` cycles.
- Simultaneous requests in the same cycle are resolved purely by the round-robin pointer.
- `owner_o` is valid whenever `busy_o=1` and holds its value in IDLE.

## Configuration
- `UART_TX_ARB_PARITY_EN`
  - Defined: insert a PARITY state between DATA and STOP. It drives even parity, the XOR of the 8 data bits, for `DIVISOR` cycles. Frame becomes `11*DIVISOR` cycles; grant spacing becomes `11*DIVISOR+1`.
  - Undefined: 8N1 only; the PARITY state does not exist.

## Structure
- Package `uart_tx_arb_pkg`:
  - FSM state enum.
  - Function `divisor(clk_hz, baud)`.
  - Constant `DATA_BITS=8`.
  - Frame bit count, dependent on the parity macro.
- Sub-module `baud_tick`:
  - Counter with a synchronous `clr_i`.
  - Pulses `tick_o` on the cycle the count reaches `DIVISOR-1`, then wraps to 0.
  - The FSM advances one bit per tick.

## Test plan
Defaults throughout, giving `DIVISOR=313`.
1. Single request, `req_i=01`, `data_i[7:0]=8'h55` -> `gnt_o=01` for 1 cycle; `tx_o` = 0,1,0,1,0,1,0,1,0,1 with each bit 313 cycles; `busy_o` high for 3130 cycles.
2. `req_i=11` in the same cycle after reset, bytes 8'hA1 / 8'h3C -> requester 0 is granted first with `owner_o=0`; requester 1 is granted 3131 cycles later; LSB-first bit order is checked on both frames.
3. `req_i=11` held for 4 frames -> grant order 0,1,0,1; `owner_o` matches each frame.
4. Reset asserted 1000 cycles into a frame -> `tx_o=1` and `busy_o=0` without waiting for a clock edge, no `gnt_o`; after release with `req_i=10`, requester 1 is granted on the next edge.
5. With `N_REQ=4`, `last_q=1`, and `req_i=1001` -> requester 3 is granted, then requester 0.
6. With `UART_TX_ARB_PARITY_EN` defined, byte 8'h07 -> parity bit 1 appears before the stop bit; frame is 3443 cycles.
